// File: rtl/scan_mux_nx1.sv
// Purpose: registered N-to-1 mux with manual select or round-robin auto-scan, tagging each word with its channel and a scan-wrap marker.
// Latency: 1 cycle from d to y; 2 cycles from a sel_load strobe to y showing the new channel.
// Backpressure: none; en=0 freezes the block (outputs hold, y_valid low).
//
// Optional build macro: SCAN_MUX_PARITY_EN adds output y_par (XOR reduction of the selected word, registered with y).
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   en, mode           block enable; 0 = manual select, 1 = auto-scan
//   sel, sel_load      manual channel select and its capture strobe
//   d                  packed inputs, channel k at [k*WIDTH +: WIDTH]
//   y, y_ch, y_valid   registered selected word, its channel, valid flag
//   wrap               one-cycle pulse when the scan shows channel 0 again
//   sel_err            one-cycle pulse when an out-of-range sel is rejected
module scan_mux_nx1 #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_valid,
  output logic                      wrap,
  output logic                      sel_err
`ifdef SCAN_MUX_PARITY_EN
  ,
  output logic                      y_par
`endif
);

  // A dwell of one cycle still needs a 1-bit counter to keep widths legal.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   NUM_CH   = (SEL_W + 1)'(CHANNELS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ch_reg, ch_d;
  logic [CNT_W-1:0]   dwell_cnt, cnt_d;
  logic               wrap_pend, pend_d;
  logic [WIDTH-1:0]   y_d;
  logic [SEL_W-1:0]   y_ch_d;
  logic               wrap_d;
  logic               err_d;
  logic [WIDTH-1:0]   sel_word;
  logic               sel_ok;

  assign sel_word = d[ch_reg*WIDTH +: WIDTH];
  // Zero-extend so the compare is meaningful when CHANNELS is a power of two.
  assign sel_ok   = ({1'b0, sel} < NUM_CH);

  // The state register records the mode of the last edge, so "valid" is
  // simply "the last edge was an active one".
  assign y_valid  = (state_q != IDLE);

  always_comb begin
    state_d = IDLE;
    ch_d    = ch_reg;
    cnt_d   = dwell_cnt;
    pend_d  = wrap_pend;
    y_d     = y;
    y_ch_d  = y_ch;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    if (en) begin
      state_d = mode ? SCAN : MANUAL;
    end

    if (state_d != IDLE) begin
      y_d    = sel_word;
      y_ch_d = ch_reg;
      // The 3->0 step is taken one edge before y_ch shows 0, so the wrap
      // marker is carried over in wrap_pend and released with that word.
      wrap_d = wrap_pend;
      pend_d = 1'b0;
    end

    case (state_d)
      MANUAL: begin
        cnt_d = '0;
        if (sel_load) begin
          if (sel_ok) begin
            ch_d = sel;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (dwell_cnt == LAST_CNT) begin
          cnt_d = '0;
          if (ch_reg == LAST_CH) begin
            ch_d   = '0;
            pend_d = 1'b1;
          end else begin
            ch_d = ch_reg + 1'b1;
          end
        end else begin
          cnt_d = dwell_cnt + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_reg    <= '0;
      dwell_cnt <= '0;
      wrap_pend <= 1'b0;
      y         <= '0;
      y_ch      <= '0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_reg    <= ch_d;
      dwell_cnt <= cnt_d;
      wrap_pend <= pend_d;
      y         <= y_d;
      y_ch      <= y_ch_d;
      wrap      <= wrap_d;
      sel_err   <= err_d;
    end
  end

`ifdef SCAN_MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (en) begin
      y_par <= ^sel_word;
    end
  end
`endif

endmodule
